// File: rtl/bsg_fifo_rolly_pkg.sv
// Shared types for the rolly FIFO replay reader: controller states and response encoding.
package bsg_fifo_rolly_pkg;

   typedef enum logic [1:0] {
      eSend   = 2'd0,
      eRewind = 2'd1,
      eError  = 2'd2
   } rolly_state_e;

   localparam logic resp_ack_lp  = 1'b1;
   localparam logic resp_nack_lp = 1'b0;

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Saturating up-counter with synchronous clear; clear has priority over count.
module bsg_counter_clear_up #(
   parameter  int unsigned max_val_p = 63,
   localparam int unsigned width_lp  = $clog2(max_val_p + 1)
) (
   input  logic                clk_i,
   input  logic                reset_n_i,
   input  logic                clear_i,
   input  logic                up_i,
   output logic [width_lp-1:0] count_o
);

   always_ff @(posedge clk_i) begin
      if (!reset_n_i || clear_i) begin
         count_o <= '0;
      end else if (up_i && (count_o != width_lp'(max_val_p))) begin
         count_o <= count_o + width_lp'(1);
      end
   end

endmodule

// File: rtl/bsg_fifo_rolly_replay_reader.sv
// Speculative reader for a rolly FIFO: dequeues to a lossy link, commits on ack,
// rewinds and replays the window on nack or response timeout.
module bsg_fifo_rolly_replay_reader
   import bsg_fifo_rolly_pkg::*;
#(
   parameter  int unsigned width_p           = 32,
   parameter  int unsigned max_outstanding_p = 8,
   parameter  int unsigned timeout_p         = 64,
   parameter  int unsigned max_retries_p     = 4,
   localparam int unsigned out_w_lp          = $clog2(max_outstanding_p + 1)
) (
   input  logic                clk_i,
   input  logic                reset_n_i,

   input  logic                fifo_v_i,
   input  logic [width_p-1:0]  fifo_data_i,
   output logic                fifo_deq_o,
   output logic                fifo_rewind_o,
   output logic                fifo_forward_o,

   output logic                v_o,
   output logic [width_p-1:0]  data_o,
   input  logic                ready_and_i,

   input  logic                resp_v_i,
   input  logic                resp_ack_i,

   output logic [out_w_lp-1:0] outstanding_o,
   output logic                error_o
);

   localparam int unsigned retry_w_lp = $clog2(max_retries_p + 1);
   localparam int unsigned tmo_w_lp   = $clog2(timeout_p);

   rolly_state_e          state_r;
   logic [out_w_lp-1:0]   outstanding_r;
   logic [retry_w_lp-1:0] retries_r;
   logic [tmo_w_lp-1:0]   tmo_cnt;

   logic send_w, timeout_hit_w, nack_w, ack_w, window_open_w, retry_last_w;
   logic tmo_clear_w;

   // Response decode; a response in the terminal timeout cycle beats the timeout.
   always_comb begin
      send_w        = (state_r == eSend);
      timeout_hit_w = send_w & (tmo_cnt == tmo_w_lp'(timeout_p - 1)) & ~resp_v_i;
      nack_w        = send_w & ((resp_v_i & (resp_ack_i == resp_nack_lp)) | timeout_hit_w);
      ack_w         = send_w & resp_v_i & (resp_ack_i == resp_ack_lp);
      window_open_w = (outstanding_r < out_w_lp'(max_outstanding_p));
      retry_last_w  = (retries_r == retry_w_lp'(max_retries_p - 1));
   end

   // Link and FIFO strobes are combinational so a head entry goes out with zero latency.
   always_comb begin
      v_o            = send_w & fifo_v_i & window_open_w & ~nack_w;
      fifo_deq_o     = v_o & ready_and_i;
      fifo_rewind_o  = nack_w;
      fifo_forward_o = ack_w & ((outstanding_r != '0) | fifo_deq_o);
      data_o         = fifo_data_i;
      outstanding_o  = outstanding_r;
      error_o        = (state_r == eError);
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_r       <= eSend;
         outstanding_r <= '0;
         retries_r     <= '0;
      end else begin
         case (state_r)
            eSend: begin
               if (fifo_rewind_o) begin
                  outstanding_r <= '0;
                  retries_r     <= retries_r + retry_w_lp'(1);
                  state_r       <= retry_last_w ? eError : eRewind;
               end else if (fifo_forward_o) begin
                  outstanding_r <= '0;
                  retries_r     <= '0;
               end else begin
                  outstanding_r <= outstanding_r + out_w_lp'(fifo_deq_o);
               end
            end
            // One bubble lets the rewound FIFO head settle before sending again.
            eRewind: begin
               outstanding_r <= '0;
               state_r       <= eSend;
            end
            eError: begin
               outstanding_r <= '0;
            end
            default: begin
               outstanding_r <= '0;
               state_r       <= eSend;
            end
         endcase
      end
   end

   always_comb begin
      tmo_clear_w = ~send_w | resp_v_i | (outstanding_r == '0) | fifo_rewind_o;
   end

   bsg_counter_clear_up #(
      .max_val_p (timeout_p - 1)
   ) tmo_counter (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .clear_i   (tmo_clear_w),
      .up_i      (1'b1),
      .count_o   (tmo_cnt)
   );

   always @(posedge clk_i) begin
      if (reset_n_i) begin
         assert (!(fifo_rewind_o && (fifo_deq_o || fifo_forward_o)));
         assert (!(fifo_rewind_o && fifo_forward_o));
         assert (outstanding_r <= out_w_lp'(max_outstanding_p));
         assert (!(fifo_deq_o && !fifo_v_i));
      end
   end

endmodule
